carregador_programa: RTL and testbench
======================================

Name: carregador_programa

Overview:
- Program loader directly upstream of the single-cycle datapath.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory's word-addressed write port, matching the PC's +1-per-instruction addressing.
- Holds the datapath in reset until the image is fully loaded, then releases it.

Parameters:
- IM_DEPTH, 256, number of 32-bit words in instruction memory; maximum image length.
- ADDR_W, 8, width of the word address; must satisfy 2**ADDR_W >= IM_DEPTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  ADDR_W  word address of the write.
- im_wdata  output  32  assembled instruction word.
- core_reset  output  1  reset for the datapath; high while loading.
- done  output  1  image loaded and core released.
- error  output  1  load aborted.

Behaviour:
- Reset (async, any state):
  - Values: state=IDLE, byte_ready=0, im_we=0, im_addr=0, im_wdata=0, core_reset=1, done=0, error=0.
  - Byte counter, word counter and partial word are cleared; a partial word is discarded.
- Handshake: a byte transfers only on a cycle where byte_valid && byte_ready. byte_ready is combinational from state: 1 in LEN_LO, LEN_HI, DATA (and CHK); 0 elsewhere.
- Stream format: count N as 16-bit little-endian (low byte, then high byte), then 4*N bytes, each word least-significant byte first.
- States and transitions:
  - IDLE: wait for start.
  - LEN_LO: capture low count byte; go to LEN_HI.
  - LEN_HI: capture high count byte, then on the next cycle:
    - N > IM_DEPTH: go to ERROR.
    - N == 0: go to DONE (or CHK).
    - Otherwise: go to DATA.
  - DATA: 2-bit byte index selects the lane.
    - On the 4th byte, the next cycle has im_we=1, im_wdata=assembled word, im_addr=word index. The word index then increments.
    - After word N-1 is accepted, the next state is DONE (or CHK).
  - DONE: done=1, core_reset=0; held until start or reset.
  - ERROR: error=1, core_reset=1; held until start or reset.
- Latency:
  - Write strobe: 1 cycle after the 4th byte handshake.
  - Core release: core_reset falls in the cycle after the last im_we pulse, never in the same cycle.
- start behaviour:
  - Ignored in LEN_LO, LEN_HI, DATA and CHK.
  - In IDLE, DONE or ERROR it enters LEN_LO. done and error clear, core_reset rises the next cycle, and counters clear.
- im_addr and im_wdata hold their last values when im_we=0.
- Addressing is bounded by N <= IM_DEPTH, so no wrap-around.
- Bytes presented while byte_ready=0 are not consumed; there is no backpressure timeout.

Optional Feature:
- CARREGADOR_CHECKSUM_EN defined:
  - After the last data word, state CHK accepts one byte.
  - The XOR of all preceding bytes (count and data) must equal it: match goes to DONE, mismatch goes to ERROR.
  - Words already written stay in memory, but core_reset remains 1.
- Not defined: CHK does not exist; the last data word or N==0 goes straight to DONE.

Decomposition:
- Shared package / include file holds:
  - State encodings: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR.
  - IM_DEPTH default.
  - Instruction-word width constant (32).
- One sub-module, montador_palavra: byte-lane shift register plus 2-bit byte index. It outputs word_valid and the 32-bit word, and has a clear input driven on start and reset.

Test Plan:
- Load, N=2: start; bytes 02 00 13 05 10 00 B3 05 B5 00 -> im_we pulses with addr0=0x00100513 and addr1=0x00B505B3; core_reset falls 1 cycle after the 2nd pulse; done=1.
- Empty image: start; bytes 00 00 -> no im_we; DONE; core_reset=0.
- Oversize: IM_DEPTH=256; bytes 01 01 (N=257) -> ERROR; no im_we; error=1; core_reset=1.
- Backpressure/gaps: byte_valid toggled randomly during the N=2 image -> identical writes; each byte consumed exactly once.
- Async reset mid-DATA after 6 bytes -> immediately core_reset=1, done=0, byte_ready=0; a restart with the full image loads from addr 0.
- Checksum (CARREGADOR_CHECKSUM_EN): N=1 word 0x00000013, checksum byte 0x12 -> DONE; checksum byte 0x00 -> ERROR with core_reset=1.

Source files
------------

// File: rtl/carregador_programa_pkg.sv
// ---------------------------------------------------------------------------
// carregador_programa_pkg
// Shared definitions for the program loader.
//   - State encoding of the loader FSM.
//   - Default instruction-memory depth and the instruction / byte widths.
//   - Helper that tells which states accept stream bytes.
// ---------------------------------------------------------------------------
package carregador_programa_pkg;

    localparam int IM_DEPTH_DEFAULT = 256;
    localparam int WORD_W           = 32;
    localparam int BYTE_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // States in which the loader is willing to take a byte off the stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/carregador_programa_if.sv
// ---------------------------------------------------------------------------
// carregador_programa_if
// Bundles the byte-stream handshake and the instruction-memory write port.
//   byte_valid / byte_data / byte_ready : incoming byte stream
//   im_we / im_addr / im_wdata          : word-addressed memory write port
// Modports:
//   slave  : loader side (consumes bytes, drives the memory write port)
//   master : producer side (drives bytes, observes the memory write port)
// Parameter ADDR_W must match the loader instance.
// ---------------------------------------------------------------------------
interface carregador_programa_if #(
    parameter int ADDR_W = 8
) ();

    logic                                       byte_valid;
    logic [carregador_programa_pkg::BYTE_W-1:0] byte_data;
    logic                                       byte_ready;
    logic                                       im_we;
    logic [ADDR_W-1:0]                          im_addr;
    logic [carregador_programa_pkg::WORD_W-1:0] im_wdata;

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

endinterface

// File: rtl/carregador_programa_montador_palavra.sv
// ---------------------------------------------------------------------------
// montador_palavra
// Assembles four stream bytes into one little-endian 32-bit word.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : synchronous clear of lane index and partial word
//   byte_en     : byte_in is accepted this cycle
//   byte_in     : stream byte
//   byte_idx    : lane the next accepted byte lands in (3 = last byte of word)
//   word_valid  : one-cycle pulse, the cycle after the 4th byte
//   word        : last completed word; held between pulses
// ---------------------------------------------------------------------------
module montador_palavra
    import carregador_programa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [1:0]        byte_idx,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [23:0]       lanes_q;
    logic [1:0]        idx_q;
    logic              valid_q;
    logic [WORD_W-1:0] word_q;

    // Bytes 0..2 are parked in their lanes; the 4th byte completes the word,
    // which is registered together with a one-cycle valid pulse. The word
    // register is left alone by clear so the memory data bus holds its value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_q <= '0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            word_q  <= '0;
        end else if (clear) begin
            lanes_q <= '0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (byte_en) begin
                if (idx_q == 2'd3) begin
                    word_q  <= {byte_in, lanes_q};
                    valid_q <= 1'b1;
                    idx_q   <= 2'd0;
                    lanes_q <= '0;
                end else begin
                    lanes_q[{idx_q, 3'b000} +: 8] <= byte_in;
                    idx_q                         <= idx_q + 2'd1;
                end
            end
        end
    end

    assign byte_idx   = idx_q;
    assign word_valid = valid_q;
    assign word       = word_q;

endmodule

// File: rtl/carregador_programa.sv
// ---------------------------------------------------------------------------
// carregador_programa
// Program loader in front of the single-cycle datapath. Takes a byte stream
// (16-bit little-endian word count N, then 4*N bytes, LSB first per word),
// writes each word into instruction memory at word addresses 0..N-1 and keeps
// the datapath in reset until the whole image is in place.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : one-cycle pulse starting a load (honoured in IDLE/DONE/ERROR)
//   bus         : byte stream + instruction-memory write port (slave modport)
//   core_reset  : datapath reset, high unless the image is loaded
//   done        : image loaded, core released
//   error       : load aborted
// Parameters: IM_DEPTH (max words), ADDR_W (word address width).
// Optional build macro CARREGADOR_CHECKSUM_EN: a trailing XOR checksum byte
// over all count and data bytes is required before the core is released.
// ---------------------------------------------------------------------------
module carregador_programa
    import carregador_programa_pkg::*;
#(
    parameter int IM_DEPTH = IM_DEPTH_DEFAULT,
    parameter int ADDR_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    carregador_programa_if.slave    bus,
    output logic                    core_reset,
    output logic                    done,
    output logic                    error
);

    localparam logic [16:0] DEPTH_LIM = 17'(IM_DEPTH);

`ifdef CARREGADOR_CHECKSUM_EN
    localparam state_t ST_AFTER_LOAD = ST_CHK;
`else
    localparam state_t ST_AFTER_LOAD = ST_DONE;
`endif

    state_t            state_q;
    state_t            state_d;
    logic              byte_ready;
    logic              hs;
    logic              restart;
    logic [7:0]        len_lo_q;
    logic [15:0]       n_q;
    logic [15:0]       n_full;
    logic              len_over;
    logic [15:0]       word_cnt_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic              last_word;
    logic [1:0]        byte_idx;
    logic              word_valid;
    logic [WORD_W-1:0] word;
`ifdef CARREGADOR_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign byte_ready = accepts_bytes(state_q);
    assign hs         = bus.byte_valid && byte_ready;
    assign restart    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign n_full     = {bus.byte_data, len_lo_q};
    assign len_over   = ({1'b0, n_full} > DEPTH_LIM);
    assign last_word  = (word_cnt_q == (n_q - 16'd1));

    montador_palavra u_montador (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_en    (hs && (state_q == ST_DATA)),
        .byte_in    (bus.byte_data),
        .byte_idx   (byte_idx),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The length decision uses the high count byte straight
    // off the bus so the state after LEN_HI already reflects the full count.
    // The DATA exit fires on the 4th byte of the last word, so the final write
    // pulse appears in the first cycle of the following state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (hs) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (hs) begin
                    if (len_over) begin
                        state_d = ST_ERROR;
                    end else if (n_full == 16'd0) begin
                        state_d = ST_AFTER_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (hs && (byte_idx == 2'd3) && last_word) state_d = ST_AFTER_LOAD;
            end
            ST_CHK: begin
`ifdef CARREGADOR_CHECKSUM_EN
                if (hs) state_d = (bus.byte_data == csum_q) ? ST_DONE : ST_ERROR;
`else
                state_d = ST_ERROR;
`endif
            end
            ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_LEN_LO;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Length capture, word counter, write address and (optionally) the
    // running XOR checksum. The write address is latched on the 4th byte so
    // it lines up with the word pulse coming out of the assembler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo_q   <= '0;
            n_q        <= '0;
            word_cnt_q <= '0;
            im_addr_q  <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else if (restart) begin
            len_lo_q   <= '0;
            n_q        <= '0;
            word_cnt_q <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else if (hs) begin
            case (state_q)
                ST_LEN_LO: len_lo_q <= bus.byte_data;
                ST_LEN_HI: n_q      <= n_full;
                ST_DATA: begin
                    if (byte_idx == 2'd3) begin
                        im_addr_q  <= word_cnt_q[ADDR_W-1:0];
                        word_cnt_q <= word_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
`ifdef CARREGADOR_CHECKSUM_EN
            if (state_q != ST_CHK) csum_q <= csum_q ^ bus.byte_data;
`endif
        end
    end

    // Core release is held back while the final write pulse is on the bus,
    // so core_reset drops the cycle after the last im_we.
    assign bus.byte_ready = byte_ready;
    assign bus.im_we      = word_valid;
    assign bus.im_addr    = im_addr_q;
    assign bus.im_wdata   = word;
    assign core_reset     = (state_q != ST_DONE) || word_valid;
    assign done           = (state_q == ST_DONE) && !word_valid;
    assign error          = (state_q == ST_ERROR);

endmodule

// File: tb/tb_carregador_programa.sv
// ---------------------------------------------------------------------------
// tb_carregador_programa
// Directed, table-driven bench for carregador_programa (IM_DEPTH=256,
// ADDR_W=8). Honours CARREGADOR_CHECKSUM_EN by appending checksum bytes.
// ---------------------------------------------------------------------------
module tb_carregador_programa;

`ifdef CARREGADOR_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic core_reset;
    logic done;
    logic error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    carregador_programa_if #(.ADDR_W(8)) bus ();

    carregador_programa #(
        .IM_DEPTH (256),
        .ADDR_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        logic [0:11][7:0] bytes;
        int               nbytes;
        bit               gaps;
        int               nwrites;
        logic [31:0]      w0;
        logic [31:0]      w1;
        logic             exp_done;
        logic             exp_error;
    } vec_t;

    vec_t        vecs[6];
    logic [7:0]  stream[$];
    logic [31:0] exp_data[$];
    logic [7:0]  got_addr[$];
    logic [31:0] got_data[$];
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          cr_fall_cyc = -1;
    logic        prev_cr = 1'b1;

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Write monitor: records every im_we pulse and the cycle core_reset drops.
    always @(negedge clk) begin
        cyc++;
        if (bus.im_we === 1'b1) begin
            got_addr.push_back(bus.im_addr);
            got_data.push_back(bus.im_wdata);
            last_we_cyc = cyc;
            checkOutput("core_reset_during_write", {31'd0, core_reset}, 32'd1);
        end
        if (prev_cr && !core_reset) cr_fall_cyc = cyc;
        prev_cr = core_reset;
    end

    function automatic vec_t mk(input logic [0:11][7:0] b, input int n, input bit g, input int nw,
                                input logic [31:0] w0, input logic [31:0] w1, input logic d, input logic e);
        vec_t v;
        v.bytes = b; v.nbytes = n; v.gaps = g; v.nwrites = nw;
        v.w0 = w0; v.w1 = w1; v.exp_done = d; v.exp_error = e;
        return v;
    endfunction

    // Called at a falling edge; returns at a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present the first 'count' bytes of the stream, optionally with idle gaps.
    task automatic feed_stream(input int count, input bit gaps);
        int i = 0;
        int budget = 0;
        bit hs;
        while (i < count && budget < 4000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'hFF;
            end else begin
                bus.byte_valid = 1'b1;
                bus.byte_data  = stream[i];
            end
            #1;
            hs = bus.byte_valid && bus.byte_ready;
            @(posedge clk);
            if (hs) i++;
            @(negedge clk);
            budget++;
        end
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        checkOutput("bytes_consumed", i, count);
    endtask

    // Run a full load of 'stream' and check writes, final flags and timing.
    task automatic run_load(input string tag, input bit gaps, input logic exp_done, input logic exp_error);
        int n;
        got_addr.delete();
        got_data.delete();
        cr_fall_cyc = -1;
        pulse_start();
        checkOutput({tag, "_start_core_reset"}, {31'd0, core_reset}, 32'd1);
        checkOutput({tag, "_start_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_start_error"}, {31'd0, error}, 32'd0);
        checkOutput({tag, "_start_ready"}, {31'd0, bus.byte_ready}, 32'd1);
        feed_stream(stream.size(), gaps);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_write_count"}, got_data.size(), exp_data.size());
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), {24'd0, got_addr[i]}, i);
            checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
        checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        checkOutput({tag, "_error"}, {31'd0, error}, {31'd0, exp_error});
        checkOutput({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, !exp_done});
        checkOutput({tag, "_ready_idle"}, {31'd0, bus.byte_ready}, 32'd0);
        if (exp_done && exp_data.size() > 0)
            checkOutput({tag, "_release_lag"}, cr_fall_cyc, last_we_cyc + 1);
    endtask

    task automatic applyStimulus(input int k);
        stream.delete();
        exp_data.delete();
        for (int i = 0; i < vecs[k].nbytes; i++) stream.push_back(vecs[k].bytes[i]);
        if (vecs[k].nwrites > 0) exp_data.push_back(vecs[k].w0);
        if (vecs[k].nwrites > 1) exp_data.push_back(vecs[k].w1);
        run_load($sformatf("v%0d", k), vecs[k].gaps, vecs[k].exp_done, vecs[k].exp_error);
    endtask

    initial begin
        vecs[0] = mk({8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00, 8'h07, 8'h00},
                     10 + CK, 1'b0, 2, 32'h00100513, 32'h00B505B3, 1'b1, 1'b0);
        vecs[1] = mk({12{8'h00}}, 2 + CK, 1'b0, 0, 32'h0, 32'h0, 1'b1, 1'b0);
        vecs[2] = mk({8'h01, 8'h01, {10{8'h00}}}, 2, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1);
        vecs[3] = mk({8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00, 8'h07, 8'h00},
                     10 + CK, 1'b1, 2, 32'h00100513, 32'h00B505B3, 1'b1, 1'b0);
        vecs[4] = mk({8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12, {5{8'h00}}},
                     6 + CK, 1'b0, 1, 32'h00000013, 32'h0, 1'b1, 1'b0);
`ifdef CARREGADOR_CHECKSUM_EN
        vecs[5] = mk({8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, {5{8'h00}}},
                     7, 1'b0, 1, 32'h00000013, 32'h0, 1'b0, 1'b1);
`else
        vecs[5] = mk({8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, {6{8'h00}}},
                     6, 1'b0, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
`endif

        reset          = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
        checkOutput("rst_im_we", {31'd0, bus.im_we}, 32'd0);
        checkOutput("rst_im_addr", {24'd0, bus.im_addr}, 32'd0);
        checkOutput("rst_im_wdata", bus.im_wdata, 32'd0);
        checkOutput("rst_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", {31'd0, bus.byte_ready}, 32'd0);
        checkOutput("idle_core_reset", {31'd0, core_reset}, 32'd1);

        for (int k = 0; k < 6; k++) applyStimulus(k);

        // Full-depth image: N=256, word w is {w,w,w,w}.
        stream.delete();
        exp_data.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h01);
        for (int w = 0; w < 256; w++) begin
            for (int b = 0; b < 4; b++) stream.push_back(w[7:0]);
            exp_data.push_back({4{w[7:0]}});
        end
        if (CK == 1) stream.push_back(8'h01);
        run_load("full", 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of DATA, then a clean reload.
        stream.delete();
        for (int i = 0; i < 10 + CK; i++) stream.push_back(vecs[0].bytes[i]);
        pulse_start();
        feed_stream(6, 1'b0);
        checkOutput("mid_ready", {31'd0, bus.byte_ready}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("arst_done", {31'd0, done}, 32'd0);
        checkOutput("arst_ready", {31'd0, bus.byte_ready}, 32'd0);
        checkOutput("arst_im_we", {31'd0, bus.im_we}, 32'd0);
        checkOutput("arst_im_wdata", bus.im_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
